// File: rtl/process_fft_if.sv
// Bus bundle between the post-FFT frame copier and its two RAMs:
// the FFT-output RAM read port and the history RAM write port.
interface process_fft_if;
   logic [11:0] fhead;   // current write head of the circular FFT-output RAM
   logic [11:0] faddr;   // read address into the FFT-output RAM
   logic [15:0] fdata;   // read data returned by the FFT-output RAM
   logic        ready;   // single-cycle "new frame available" pulse
   logic [9:0]  haddr;   // history RAM write address
   logic [15:0] hdata;   // history RAM write data
   logic        hwe;     // history RAM write enable
   logic        error;   // sticky overrun flag

   // Environment side: FFT stage and RAM models
   modport master (
      output fhead, fdata, ready,
      input  faddr, haddr, hdata, hwe, error
   );

   // Copier side
   modport slave (
      input  fhead, fdata, ready,
      output faddr, haddr, hdata, hwe, error
   );
endinterface

// File: rtl/process_fft.sv
// Post-FFT frame copier: on each ready pulse, copies NBINS consecutive bins
// from the circular FFT-output RAM (starting at the write head) into the
// history RAM, scaling each bin by a logical right shift. A ready that
// arrives while a copy is in flight is dropped and latches a sticky error.
module process_fft #(
   parameter int NBINS        = 1024,  // bins copied per frame (<= 1024)
   parameter int READ_LATENCY = 1,     // FFT RAM read latency, 1..4
   parameter int SHIFT        = 0      // right shift applied to each bin, 0..15
) (
   input  logic          clk,
   input  logic          reset_n,
   process_fft_if.slave  bus
);

   localparam int CW = 11;  // wide enough to count 0..NBINS-1 without overflow

   typedef enum logic {IDLE, READ} state_t;

   state_t          state_q;
   logic [11:0]     base_q;      // fhead latched at frame start
   logic [11:0]     faddr_q;
   logic [CW-1:0]   issue_q;     // index of the most recently issued read
   logic [READ_LATENCY:0] vld_q; // stage 0 = address issued this cycle
   logic [9:0]      idx_q [READ_LATENCY+1];
   logic [9:0]      haddr_q;
   logic [15:0]     hdata_q;
   logic            hwe_q;
   logic            error_q;

   logic            issue_more;
   logic [CW-1:0]   issue_d;
   logic [11:0]     faddr_d;
   logic            last_wr;

   // Next read address and end-of-frame detection
   always_comb begin
      issue_more = (state_q == READ) && (issue_q < CW'(NBINS - 1));
      issue_d    = issue_q + CW'(1);
      faddr_d    = base_q + 12'(issue_d);   // 12-bit add wraps 4095 -> 0
      last_wr    = vld_q[READ_LATENCY] && (idx_q[READ_LATENCY] == 10'(NBINS - 1));
   end

   // Frame FSM, read-address generator, valid/index pipeline and write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         faddr_q <= '0;
         issue_q <= '0;
         vld_q   <= '0;
         for (int s = 0; s <= READ_LATENCY; s++) idx_q[s] <= '0;
         haddr_q <= '0;
         hdata_q <= '0;
         hwe_q   <= 1'b0;
         error_q <= 1'b0;
      end else begin
         // The pipeline shifts every cycle; stage 0 is refilled below only
         // when a new address goes out.
         for (int s = 1; s <= READ_LATENCY; s++) begin
            vld_q[s] <= vld_q[s-1];
            idx_q[s] <= idx_q[s-1];
         end
         vld_q[0] <= 1'b0;

         // Data for the oldest stage is on fdata now: register the write.
         // haddr/hdata hold their values whenever no write is pending.
         hwe_q <= vld_q[READ_LATENCY];
         if (vld_q[READ_LATENCY]) begin
            haddr_q <= idx_q[READ_LATENCY];
            hdata_q <= bus.fdata >> SHIFT;
         end

         case (state_q)
            IDLE: begin
               if (bus.ready) begin
                  state_q  <= READ;
                  base_q   <= bus.fhead;
                  faddr_q  <= bus.fhead;
                  issue_q  <= '0;
                  vld_q[0] <= 1'b1;
                  idx_q[0] <= '0;
               end
            end
            READ: begin
               // A new frame during a copy is dropped, not queued.
               if (bus.ready) error_q <= 1'b1;
               if (issue_more) begin
                  issue_q  <= issue_d;
                  faddr_q  <= faddr_d;
                  vld_q[0] <= 1'b1;
                  idx_q[0] <= issue_d[9:0];
               end
               // Leave on the edge that registers the final write so the
               // very next ready is accepted.
               if (last_wr) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.faddr = faddr_q;
   assign bus.haddr = haddr_q;
   assign bus.hdata = hdata_q;
   assign bus.hwe   = hwe_q;
   assign bus.error = error_q;

endmodule

// File: tb/tb_process_fft.sv
// Directed bench for process_fft: a default instance (SHIFT=0, latency 1)
// and a second instance (SHIFT=4, latency 2) share clock, reset, fhead and
// ready. Each has its own synchronous RAM model for fdata.
module tb_process_fft;

   logic        clk;
   logic        reset_n;
   logic [11:0] fhead;
   logic        ready;
   logic        mode;      // 0: constant 0x93DA, 1: {4'h0, addr}
   logic [11:0] tb_base;   // base address of the frame being checked

   int checks = 0;
   int errors = 0;

   process_fft_if bus0 ();
   process_fft_if bus1 ();

   process_fft #(.NBINS(1024), .READ_LATENCY(1), .SHIFT(0)) u0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0));
   process_fft #(.NBINS(1024), .READ_LATENCY(2), .SHIFT(4)) u1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] fmodel(input logic [11:0] a);
      return mode ? {4'h0, a} : 16'h93DA;
   endfunction

   // RAM models: one-cycle and two-cycle registered reads
   logic [15:0] fd0, fd1a, fd1b;
   always @(posedge clk) begin
      fd0  <= fmodel(bus0.faddr);
      fd1a <= fmodel(bus1.faddr);
      fd1b <= fd1a;
   end

   assign bus0.fhead = fhead;
   assign bus1.fhead = fhead;
   assign bus0.ready = ready;
   assign bus1.ready = ready;
   assign bus0.fdata = fd0;
   assign bus1.fdata = fd1b;

   // Write monitor: counts writes, bursts, address-sequence and data errors
   int wr0 = 0, wr1 = 0, bursts0 = 0, serr0 = 0, derr0 = 0, derr1 = 0;
   logic        prev_hwe0 = 1'b0;
   logic [9:0]  prev_haddr0 = '0;
   logic [15:0] h100_0 = 16'hFFFF;
   always @(negedge clk) begin
      if (bus0.hwe) begin
         wr0 <= wr0 + 1;
         if (!prev_hwe0) bursts0 <= bursts0 + 1;
         if (bus0.haddr !== (prev_hwe0 ? prev_haddr0 + 10'd1 : 10'd0)) serr0 <= serr0 + 1;
         if (bus0.hdata !== fmodel(tb_base + 12'(bus0.haddr))) derr0 <= derr0 + 1;
         if (bus0.haddr == 10'h100) h100_0 <= bus0.hdata;
      end
      prev_hwe0   <= bus0.hwe;
      prev_haddr0 <= bus0.haddr;
      if (bus1.hwe) begin
         wr1 <= wr1 + 1;
         if (bus1.hdata !== (fmodel(tb_base + 12'(bus1.haddr)) >> 4)) derr1 <= derr1 + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Starts a frame (ready sampled at edge k) and steps through edges
   // k .. k+1025, tallying faddr and hwe-window deviations.
   task automatic run_frame(input logic [11:0] base, input int hold, input int ovr_j,
                            output int fa_err, output int h0_err, output int h1_err,
                            output logic err_pre, output logic err_post);
      logic [11:0] ea;
      fa_err = 0; h0_err = 0; h1_err = 0; err_pre = 1'bx; err_post = 1'bx;
      fhead   = base;
      tb_base = base;
      ready   = 1'b1;
      for (int j = 0; j <= 1025; j++) begin
         @(posedge clk);
         #1;
         if (j == hold - 1) ready = 1'b0;
         if (j == ovr_j - 1) ready = 1'b1;
         else if (j == ovr_j) ready = 1'b0;
         if (j == 10) fhead = ~base;   // must not disturb a frame in flight
         ea = base + 12'((j < 1024) ? j : 1023);
         if (bus0.faddr !== ea) fa_err++;
         if (bus0.hwe !== ((j >= 2) && (j <= 1025))) h0_err++;
         if (bus1.hwe !== ((j >= 3) && (j <= 1026))) h1_err++;
         if (j == ovr_j - 1) err_pre = bus0.error;
         if (j == ovr_j) err_post = bus0.error;
      end
      ready = 1'b0;
   endtask

   int fa, h0, h1, s_wr0, s_wr1, s_b0, s_se0, s_de0, s_de1, gap_hwe;
   logic ep, eq;
   bit found;

   task automatic snap();
      s_wr0 = wr0; s_wr1 = wr1; s_b0 = bursts0;
      s_se0 = serr0; s_de0 = derr0; s_de1 = derr1;
   endtask

   initial begin
      reset_n = 1'b0; fhead = '0; ready = 1'b0; mode = 1'b0; tb_base = '0;
      idle(3);
      chk("rst_faddr", bus0.faddr, 0);
      chk("rst_haddr", bus0.haddr, 0);
      chk("rst_hdata", bus0.hdata, 0);
      chk("rst_hwe",   bus0.hwe,   0);
      chk("rst_error", bus0.error, 0);
      reset_n = 1'b1;
      idle(3);

      // Basic frame, constant data; second instance checks shift and latency
      snap();
      run_frame(12'h000, 1, -1, fa, h0, h1, ep, eq);
      chk("A_faddr_seq", fa, 0);
      chk("A_hwe_window", h0, 0);
      chk("A_hwe_window_lat2", h1, 0);
      idle(5);
      chk("A_writes", wr0 - s_wr0, 1024);
      chk("A_bursts", bursts0 - s_b0, 1);
      chk("A_haddr_seq", serr0 - s_se0, 0);
      chk("A_hdata", derr0 - s_de0, 0);
      chk("A_last_haddr", bus0.haddr, 1023);
      chk("A_last_hdata", bus0.hdata, 16'h93DA);
      chk("A_error", bus0.error, 0);
      chk("A_writes_lat2", wr1 - s_wr1, 1024);
      chk("A_hdata_shift", derr1 - s_de1, 0);
      chk("A_last_hdata_shift", bus1.hdata, 16'h093D);

      // Wrap-around frame followed immediately by a back-to-back frame
      mode = 1'b1;
      snap();
      run_frame(12'hF00, 1, -1, fa, h0, h1, ep, eq);
      chk("B_faddr_wrap", fa, 0);
      chk("B_hwe_window", h0, 0);
      run_frame(12'hF00, 1, -1, fa, h0, h1, ep, eq);
      chk("C_faddr_wrap", fa, 0);
      chk("C_hwe_window", h0, 0);
      idle(5);
      chk("BC_writes", wr0 - s_wr0, 2048);
      chk("BC_bursts", bursts0 - s_b0, 2);
      chk("BC_haddr_seq", serr0 - s_se0, 0);
      chk("BC_hdata", derr0 - s_de0, 0);
      chk("BC_hdata_at_0x100", h100_0, 16'h0000);
      chk("BC_last_haddr", bus0.haddr, 1023);
      chk("BC_last_hdata", bus0.hdata, 16'h02FF);
      chk("BC_error", bus0.error, 0);

      // Two frames about 7000 cycles apart
      snap();
      run_frame(12'h3A5, 1, -1, fa, h0, h1, ep, eq);
      chk("D1_faddr", fa, 0);
      gap_hwe = 0;
      for (int i = 0; i < 5970; i++) begin
         @(posedge clk);
         #1;
         if (bus0.hwe !== 1'b0) gap_hwe++;
      end
      chk("D_gap_hwe_low", gap_hwe, 0);
      run_frame(12'h800, 1, -1, fa, h0, h1, ep, eq);
      chk("D2_faddr", fa, 0);
      idle(5);
      chk("D_writes", wr0 - s_wr0, 2048);
      chk("D_bursts", bursts0 - s_b0, 2);
      chk("D_hdata", derr0 - s_de0, 0);
      chk("D_error", bus0.error, 0);

      // Overrun: second ready 500 cycles into the frame
      snap();
      run_frame(12'h010, 1, 500, fa, h0, h1, ep, eq);
      chk("E_faddr", fa, 0);
      chk("E_hwe_window", h0, 0);
      chk("E_error_before", ep, 0);
      chk("E_error_after", eq, 1);
      idle(1100);
      chk("E_writes_no_second_burst", wr0 - s_wr0, 1024);
      chk("E_bursts", bursts0 - s_b0, 1);
      chk("E_hdata", derr0 - s_de0, 0);
      chk("E_error_sticky", bus0.error, 1);

      // Reset in the middle of the write burst
      fhead = 12'h200; tb_base = 12'h200; ready = 1'b1;
      idle(1);
      ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (bus0.hwe && bus0.haddr == 10'd300) found = 1'b1;
         else idle(1);
      end
      chk("F_reached_write_300", found, 1);
      reset_n = 1'b0;
      #1;
      chk("F_rst_faddr", bus0.faddr, 0);
      chk("F_rst_haddr", bus0.haddr, 0);
      chk("F_rst_hdata", bus0.hdata, 0);
      chk("F_rst_hwe",   bus0.hwe,   0);
      chk("F_rst_error", bus0.error, 0);
      idle(3);
      reset_n = 1'b1;
      snap();
      idle(20);
      chk("F_no_writes_after_reset", wr0 - s_wr0, 0);

      // Fresh frame with ready held for three cycles
      snap();
      run_frame(12'h7FF, 3, -1, fa, h0, h1, ep, eq);
      chk("G_faddr", fa, 0);
      chk("G_hwe_window", h0, 0);
      idle(5);
      chk("G_writes", wr0 - s_wr0, 1024);
      chk("G_bursts", bursts0 - s_b0, 1);
      chk("G_haddr_seq_from_0", serr0 - s_se0, 0);
      chk("G_hdata", derr0 - s_de0, 0);
      chk("G_error_from_held_ready", bus0.error, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
